// File: rtl/qspi_slave_if.sv
// qspi_slave_if: target-side QSPI serial engine, oversampled on sys_clk.
// It supports x1/x2/x4 lanes. It shifts out tx_data on master reads and
// captures rx_data on master writes.
// Optional feature macro: QSPI_SLAVE_OVERRUN_EN adds the sticky err_overrun output.
module qspi_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b1,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  nrst,
  input  logic [1:0]            sel_mode,
  input  logic                  operation,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  frame_abort,
  input  logic                  chip_select,
  input  logic                  sclk,
  inout  wire  [3:0]            IO
`ifdef QSPI_SLAVE_OVERRUN_EN
  ,
  output logic                  err_overrun
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_IGNORE} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_cs_sync, r_sclk_sync;
  logic                  r_cs_prev, r_sclk_prev;
  logic [3:0]            r_io_meta, r_io_sync;
  logic [1:0]            r_mode;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CW-1:0]         r_cnt;
  logic                  r_abort;

  logic                  w_cs_fall, w_cs_rise, w_lead, w_trail, w_sample, w_shift;
  logic                  w_start, w_abort, w_final;
  logic [CW-1:0]         w_last;
  logic [DATA_WIDTH-1:0] w_sr_in, w_sr_sh;
  logic [3:0]            w_oe, w_dout;

  // 2-FF synchronizers plus one history stage for edge detection
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      r_cs_sync   <= '1;
      r_cs_prev   <= 1'b1;
      r_sclk_sync <= {CPOL, CPOL};
      r_sclk_prev <= CPOL;
      r_io_meta   <= '0;
      r_io_sync   <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], chip_select};
      r_cs_prev   <= r_cs_sync[1];
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_sclk_prev <= r_sclk_sync[1];
      r_io_meta   <= IO;
      r_io_sync   <= r_io_meta;
    end
  end

  assign w_cs_fall = r_cs_prev & ~r_cs_sync[1];
  assign w_cs_rise = ~r_cs_prev & r_cs_sync[1];
  assign w_lead    = (r_sclk_prev == CPOL) && (r_sclk_sync[1] != CPOL);
  assign w_trail   = (r_sclk_prev != CPOL) && (r_sclk_sync[1] == CPOL);
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_shift   = CPHA ? w_lead : w_trail;

  // Per-mode beat count, shift-in/shift-out words and lane drive
  always_comb begin
    w_last  = CW'(DATA_WIDTH / 4 - 1);
    w_sr_in = {r_sr[DATA_WIDTH-5:0], r_io_sync[0], r_io_sync[1], r_io_sync[2], r_io_sync[3]};
    w_sr_sh = {r_sr[DATA_WIDTH-5:0], 4'b0000};
    w_oe    = 4'b1111;
    w_dout  = {r_sr[DATA_WIDTH-4], r_sr[DATA_WIDTH-3], r_sr[DATA_WIDTH-2], r_sr[DATA_WIDTH-1]};
    case (r_mode)
      2'b00: begin
        w_last  = CW'(DATA_WIDTH - 1);
        w_sr_in = {r_sr[DATA_WIDTH-2:0], r_io_sync[0]};
        w_sr_sh = {r_sr[DATA_WIDTH-2:0], 1'b0};
        w_oe    = 4'b0010;
        w_dout  = {2'b00, r_sr[DATA_WIDTH-1], 1'b0};
      end
      2'b01: begin
        w_last  = CW'(DATA_WIDTH / 2 - 1);
        w_sr_in = {r_sr[DATA_WIDTH-3:0], r_io_sync[0], r_io_sync[1]};
        w_sr_sh = {r_sr[DATA_WIDTH-3:0], 2'b00};
        w_oe    = 4'b0011;
        w_dout  = {2'b00, r_sr[DATA_WIDTH-2], r_sr[DATA_WIDTH-1]};
      end
      default: ;
    endcase
    if (!((r_state == S_ACTIVE || r_state == S_DONE) && !r_op)) w_oe = 4'b0000;
  end

  for (genvar g = 0; g < 4; g++) begin : g_io
    assign IO[g] = w_oe[g] ? w_dout[g] : 1'bz;
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and frame control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          if (sel_mode == 2'b11) begin
            w_state_nxt = S_IGNORE;
          end else begin
            w_state_nxt = S_ACTIVE;
            w_start     = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_sample && r_cnt == w_last) begin
          w_state_nxt = S_DONE;
          w_final     = 1'b1;
        end
      end
      S_DONE, S_IGNORE: begin
        if (w_cs_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_ACTIVE);

  // Frame datapath: latch configuration at start, then shift per beat.
  // With CPHA=1 the first leading edge presents the already-loaded top bits,
  // so shifting starts only once a beat has been sampled.
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      r_mode <= '0;
      r_op   <= 1'b0;
      r_sr   <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_mode <= sel_mode;
      r_op   <= operation;
      r_sr   <= tx_data;
      r_cnt  <= '0;
    end else if (r_state == S_ACTIVE && !w_cs_rise) begin
      if (w_sample) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_op) r_sr <= w_sr_in;
      end
      if (w_shift && !r_op && (!CPHA || r_cnt != '0)) r_sr <= w_sr_sh;
    end
  end

  // Receive word hand-off and abort pulse
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (w_final && r_op) begin
        rx_data  <= w_sr_in;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign frame_abort = r_abort;

`ifdef QSPI_SLAVE_OVERRUN_EN
  // Sticky flag: a new write word landed on an unacknowledged one
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst)                                      err_overrun <= 1'b0;
    else if (w_final && r_op && rx_valid && !rx_ack) err_overrun <= 1'b1;
  end
`endif

endmodule
